// File: rtl/ntt_pkg.sv
// ntt_pkg: shared FSM state type, default transform size and stage-count helpers
//   LOG_N_DEF     : default log2 of the transform size
//   state_t       : sequencer states IDLE / RUN / FIN
//   r4_f          : number of radix-4 stages for a given log_n
//   has_r2_f      : a trailing radix-2 stage exists (odd log_n)
//   num_stages_f  : total stage count
package ntt_pkg;
    localparam int LOG_N_DEF = 9;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    function automatic int r4_f(input int log_n);
        return log_n / 2;
    endfunction

    function automatic logic has_r2_f(input int log_n);
        return (log_n % 2) == 1;
    endfunction

    function automatic int num_stages_f(input int log_n);
        return r4_f(log_n) + (has_r2_f(log_n) ? 1 : 0);
    endfunction
endpackage

// File: rtl/ntt_quad_map.sv
// ntt_quad_map: combinational (stage, j, k) to butterfly operand address mapping
//   p_i        : stage index
//   j_i, k_i   : outer/inner loop counters (k_i is the loop index i in the radix-2 stage)
//   r2_i       : current stage is the radix-2 stage
//   addr*_o    : operand addresses base + m*stride, m = 0..3
module ntt_quad_map #(
    parameter int LOG_N = 9,
    parameter int SW = 3
) (
    input  logic [SW-1:0]    p_i,
    input  logic [LOG_N-3:0] j_i,
    input  logic [LOG_N-3:0] k_i,
    input  logic             r2_i,
    output logic [LOG_N-1:0] addr0_o,
    output logic [LOG_N-1:0] addr1_o,
    output logic [LOG_N-1:0] addr2_o,
    output logic [LOG_N-1:0] addr3_o
);
    logic [LOG_N-1:0] s, base;

    always_comb begin
        // radix-4 stride is 4^p; base is k*4S + j, i.e. k shifted left by 2p+2
        s = r2_i ? LOG_N'(1) << (LOG_N - 2) : LOG_N'(1) << {p_i, 1'b0};
        base = r2_i ? LOG_N'(k_i) : ((LOG_N'(k_i) << 2) << {p_i, 1'b0}) + LOG_N'(j_i);
        addr0_o = base;
        addr1_o = base + s;
        addr2_o = base + (s << 1);
        addr3_o = base + s + (s << 1);
    end
endmodule

// File: rtl/ntt_addr_seq.sv
// ntt_addr_seq: NTT butterfly address sequencer with valid/ready quad output
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, dir          : begin a pass; stage order (0 descending, 1 ascending)
//   busy, done          : pass in progress; one-cycle end-of-pass pulse
//   out_valid/out_ready : quad handshake
//   addr0..3, stage     : operand addresses and stage index of the presented quad
//   stage_last          : presented quad is the last of its stage
module ntt_addr_seq
    import ntt_pkg::*;
#(
    parameter int LOG_N = LOG_N_DEF,
    parameter int SW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LOG_N-1:0] addr0,
    output logic [LOG_N-1:0] addr1,
    output logic [LOG_N-1:0] addr2,
    output logic [LOG_N-1:0] addr3,
    output logic [SW-1:0]    stage,
    output logic             stage_last
);
    localparam int CW = LOG_N - 2;
    localparam logic HAS_R2 = has_r2_f(LOG_N);
    localparam logic [SW-1:0] R2_P = SW'(r4_f(LOG_N));
    localparam logic [SW-1:0] LAST_P = SW'(num_stages_f(LOG_N) - 1);

    state_t state_q, state_d;
    logic [SW-1:0] p_q, p_d, p_end;
    logic [CW-1:0] j_q, j_d, k_q, k_d;
    logic dir_q, dir_d, k_last, j_last, last_d;
    logic busy_q, done_q, valid_q, last_q;
    logic [LOG_N-1:0] addr_q [4];
    logic [LOG_N-1:0] addr_d [4];

    function automatic logic is_r2(input logic [SW-1:0] p);
        return HAS_R2 && (p == R2_P);
    endfunction

    // last k value: N/(4S)-1 for radix-4, N/4-1 for radix-2
    function automatic logic [CW-1:0] kmask_f(input logic [SW-1:0] p);
        return is_r2(p) ? {CW{1'b1}} : {CW{1'b1}} >> {p, 1'b0};
    endfunction

    // last j value: S-1 for radix-4, 0 for radix-2 (no outer loop)
    function automatic logic [CW-1:0] smask_f(input logic [SW-1:0] p);
        return is_r2(p) ? '0 : ~({CW{1'b1}} << {p, 1'b0});
    endfunction

    always_comb begin
        state_d = state_q;
        p_d = p_q;
        j_d = j_q;
        k_d = k_q;
        dir_d = dir_q;
        k_last = (k_q == kmask_f(p_q));
        j_last = (j_q == smask_f(p_q));
        p_end = dir_q ? LAST_P : '0;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                dir_d = dir;
                p_d = dir ? '0 : LAST_P;
                j_d = '0;
                k_d = '0;
            end
            RUN: if (out_ready) begin
                if (!k_last) k_d = k_q + 1'b1;
                else begin
                    k_d = '0;
                    if (!j_last) j_d = j_q + 1'b1;
                    else begin
                        j_d = '0;
                        if (p_q == p_end) state_d = FIN;
                        else p_d = dir_q ? p_q + 1'b1 : p_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        last_d = (j_d == smask_f(p_d)) && (k_d == kmask_f(p_d));
    end

    ntt_quad_map #(.LOG_N(LOG_N), .SW(SW)) u_map (
        .p_i    (p_d),
        .j_i    (j_d),
        .k_i    (k_d),
        .r2_i   (is_r2(p_d)),
        .addr0_o(addr_d[0]),
        .addr1_o(addr_d[1]),
        .addr2_o(addr_d[2]),
        .addr3_o(addr_d[3])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q <= '0;
            j_q <= '0;
            k_q <= '0;
            dir_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            valid_q <= 1'b0;
            last_q <= 1'b0;
            addr_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            p_q <= p_d;
            j_q <= j_d;
            k_q <= k_d;
            dir_q <= dir_d;
            busy_q <= state_d != IDLE;
            done_q <= state_d == FIN;
            valid_q <= state_d == RUN;
            // during a stall the next-state counters equal the current ones, so this reload holds the quad
            if (state_d == RUN) begin
                addr_q <= addr_d;
                last_q <= last_d;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out_valid = valid_q;
    assign addr0 = addr_q[0];
    assign addr1 = addr_q[1];
    assign addr2 = addr_q[2];
    assign addr3 = addr_q[3];
    assign stage = p_q;
    assign stage_last = last_q;
endmodule

// File: tb/tb_ntt_addr_seq.sv
// tb_ntt_addr_seq: directed/randomized bench with a loop-level reference model of the quad stream
module tb_ntt_addr_seq;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start8 = 1'b0, dir = 1'b0, out_ready = 1'b0;
    logic busy, done, out_valid, stage_last;
    logic [8:0] a0, a1, a2, a3;
    logic [2:0] stage;
    logic busy8, done8, valid8, sl8;
    logic [7:0] b0, b1, b2, b3;
    logic [2:0] st8;
    int tests = 0, fails = 0;
    longint exp_q[$];
    longint got_q[$];

    always #5 clk = ~clk;

    ntt_addr_seq #(.LOG_N(9), .SW(3)) u9 (
        .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .addr0(a0), .addr1(a1), .addr2(a2),
        .addr3(a3), .stage(stage), .stage_last(stage_last)
    );

    ntt_addr_seq #(.LOG_N(8), .SW(3)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .dir(dir), .busy(busy8), .done(done8),
        .out_valid(valid8), .out_ready(out_ready), .addr0(b0), .addr1(b1), .addr2(b2),
        .addr3(b3), .stage(st8), .stage_last(sl8)
    );

    function automatic longint pack(input int s, input int q0, input int q1, input int q2,
                                    input int q3, input int l);
        return (longint'(l) << 60) | (longint'(s) << 48) | (longint'(q0) << 36) |
               (longint'(q1) << 24) | (longint'(q2) << 12) | longint'(q3);
    endfunction

    function automatic int fld(input longint v, input int sh);
        return int'((v >> sh) & 64'hfff);
    endfunction

    task automatic chk(input string tag, input longint obs, input longint expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // reference stream straight from the stage/loop definitions
    task automatic build(input int log_n, input bit d);
        int n, r4, ns, p, s, kc;
        exp_q.delete();
        n = 1 << log_n;
        r4 = log_n / 2;
        ns = r4 + (log_n % 2);
        for (int t = 0; t < ns; t++) begin
            p = d ? t : ns - 1 - t;
            if (p < r4) begin
                s = 1 << (2 * p);
                kc = n / (4 * s);
                for (int j = 0; j < s; j++)
                    for (int k = 0; k < kc; k++)
                        exp_q.push_back(pack(p, k*4*s + j, k*4*s + j + s, k*4*s + j + 2*s,
                                             k*4*s + j + 3*s, (j == s-1 && k == kc-1) ? 1 : 0));
            end else begin
                for (int i = 0; i < n/4; i++)
                    exp_q.push_back(pack(p, i, i + n/4, i + n/2, i + 3*n/4, (i == n/4-1) ? 1 : 0));
            end
        end
    endtask

    function automatic longint cur_quad(input bit sel);
        return sel ? pack(int'(st8), int'(b0), int'(b1), int'(b2), int'(b3), int'(sl8))
                   : pack(int'(stage), int'(a0), int'(a1), int'(a2), int'(a3), int'(stage_last));
    endfunction

    task automatic run_pass(input bit sel, input bit d, input int stall_pct, input bit spam);
        int cyc, last_hs, done_cyc, ndone;
        bit stalled, v, b, dn;
        longint held, cur;
        got_q.delete();
        cyc = 0; last_hs = -100; done_cyc = -1; ndone = 0; stalled = 0; held = 0;
        @(negedge clk);
        dir = d; out_ready = 1'b1;
        if (sel) start8 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start8 = 1'b0;
        chk("valid_rise", sel ? valid8 : out_valid, 1);
        while (cyc < 20000) begin
            v = sel ? valid8 : out_valid;
            b = sel ? busy8 : busy;
            dn = sel ? done8 : done;
            cur = cur_quad(sel);
            if (stalled) chk("stall_hold", cur, held);
            if (dn) begin ndone++; done_cyc = cyc; end
            if (!b) break;
            if (spam) begin
                start = ($urandom_range(3) == 0);
                dir = 1'($urandom_range(1));
            end
            out_ready = ($urandom_range(99) >= stall_pct);
            if (v && out_ready) begin
                chk("quad", cur, got_q.size() < exp_q.size() ? exp_q[got_q.size()] : -1);
                got_q.push_back(cur);
                last_hs = cyc;
            end
            stalled = v && !out_ready;
            held = cur;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; out_ready = 1'b0;
        chk("pass_in_budget", cyc < 20000, 1);
        chk("quad_count", got_q.size(), exp_q.size());
        chk("done_count", ndone, 1);
        chk("done_timing", done_cyc, last_hs + 1);
    endtask

    initial begin
        int n, bad, nl;
        int cnt[512];
        #1;
        chk("reset_flags", {busy, done, out_valid, stage_last}, 0);
        chk("reset_quad", cur_quad(0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        build(9, 0);
        run_pass(0, 0, 0, 0);
        chk("r9d0_first", got_q[0], pack(4, 0, 128, 256, 384, 0));
        chk("r9d0_second", got_q[1], pack(4, 1, 129, 257, 385, 0));
        chk("r9d0_stage3_first", got_q[128], pack(3, 0, 64, 128, 192, 0));
        chk("r9d0_final", got_q[got_q.size()-1], pack(0, 508, 509, 510, 511, 1));

        build(9, 1);
        run_pass(0, 1, 0, 0);
        chk("r9d1_first", got_q[0], pack(0, 0, 1, 2, 3, 0));
        chk("r9d1_second", got_q[1], pack(0, 4, 5, 6, 7, 0));
        chk("r9d1_last_stage", fld(got_q[got_q.size()-1], 48), 4);
        for (int s = 0; s < 5; s++) begin
            foreach (cnt[i]) cnt[i] = 0;
            foreach (got_q[g])
                if (fld(got_q[g], 48) == s)
                    for (int m = 0; m < 4; m++) cnt[fld(got_q[g], 36 - 12*m)]++;
            bad = 0;
            foreach (cnt[i]) if (cnt[i] != 1) bad++;
            chk($sformatf("cover_stage%0d", s), bad, 0);
        end

        build(8, 0);
        run_pass(1, 0, 0, 0);
        chk("r8_count", got_q.size(), 256);
        nl = 0;
        foreach (got_q[g]) if (((got_q[g] >> 60) & 1) == 1) nl++;
        chk("r8_last_count", nl, 4);
        chk("r8_last_64", (got_q[63] >> 60) & 1, 1);
        chk("r8_first", got_q[0], pack(3, 0, 64, 128, 192, 0));

        build(9, 0);
        run_pass(0, 0, 30, 0);
        run_pass(0, 0, 15, 1);

        @(negedge clk);
        dir = 1'b0; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int c = 0; c < 1000 && n < 200; c++) begin
            if (out_valid) n++;
            @(negedge clk);
        end
        chk("abort_reached", n, 200);
        chk("abort_running", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid_drop", out_valid, 0);
        chk("abort_busy_drop", busy, 0);
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) bad++;
        end
        chk("abort_no_done", bad, 0);
        rst_n = 1'b1;
        out_ready = 1'b0;
        run_pass(0, 0, 0, 0);
        chk("restart_first", got_q[0], pack(4, 0, 128, 256, 384, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ntt_addr_seq.md
NTT_ADDR_SEQ -- requirements
Module: ntt_addr_seq

Interface
REQ-001 SHALL have parameter LOG_N, default 9, giving transform size N = 2^LOG_N; legal range 4..12.
REQ-002 SHALL have parameter SW, default 3, giving the stage-index width; it SHALL satisfy 2^SW >= ceil(LOG_N/2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request one full transform pass.
REQ-006 SHALL have port dir, input, 1 bit: stage order, sampled at start (0 = descending, 1 = ascending).
REQ-007 SHALL have port busy, output, 1 bit: a pass is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse at pass end.
REQ-009 SHALL have port out_valid, input to the consumer, output of this block, 1 bit: the address quad is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the quad.
REQ-011 SHALL have ports addr0, addr1, addr2, addr3, outputs, LOG_N bits each: butterfly operand addresses.
REQ-012 SHALL have port stage, output, SW bits: the current stage index p.
REQ-013 SHALL have port stage_last, output, 1 bit: the current quad is the final quad of its stage.

Function
REQ-014 Stages SHALL be defined as follows.
- R4 = floor(LOG_N/2) radix-4 stages, p = 0..R4-1.
- If LOG_N is odd, one radix-2 stage, p = R4.
REQ-015 Radix-4 stage p SHALL use stride S = 4^p.
- Loop j outer over 0..S-1; loop k inner over 0..N/(4S)-1.
- base = k*4S + j.
- addrm = base + m*S, for m = 0..3.
REQ-016 The radix-2 stage SHALL loop i over 0..N/4-1 and emit addrm = i + m*N/4.
REQ-017 Every stage SHALL emit exactly N/4 quads.
REQ-018 Stage order SHALL be fixed by dir.
- dir=0: highest p first, descending to 0.
- dir=1: p = 0 first, ascending.
REQ-019 The FSM SHALL have states IDLE, RUN and FIN.
- IDLE->RUN on start.
- RUN->FIN on the handshake of the final quad of the final stage.
- FIN->IDLE unconditionally after one cycle.
REQ-020 out_valid SHALL rise the cycle after start is accepted in IDLE.
REQ-021 A quad SHALL be transferred when out_valid and out_ready are both high; the next quad SHALL be presented the following cycle, with no bubbles, including across stage boundaries.
REQ-022 While out_valid=1 and out_ready=0, addr0..3, stage and stage_last SHALL hold stable.
REQ-023 busy SHALL be high in RUN and FIN.
REQ-024 done SHALL be high only in FIN.
REQ-025 out_valid SHALL be low in IDLE and FIN.
REQ-026 start SHALL be ignored while busy, including the FIN cycle.
REQ-027 dir changes during RUN SHALL have no effect.
REQ-028 All outputs SHALL be registered; address arithmetic SHALL be LOG_N bits wide with no overflow, since every address is < N by construction.

Reset
REQ-029 On rst_n low, asynchronously: state=IDLE; busy, done and out_valid = 0; addr0..3 = 0; stage = 0; stage_last = 0; all counters = 0.
REQ-030 Reset during RUN SHALL abandon the pass without asserting done; the next start SHALL begin a fresh pass.

Structure
REQ-031 Shared package ntt_pkg SHALL hold the following.
- The FSM state enum.
- The LOG_N default.
- Functions for R4, the radix-2 stage presence flag, and the total stage count.
REQ-032 The stage/j/k-to-address mapping SHALL be a combinational sub-module ntt_quad_map, with inputs p, j, k and radix-2 flag and outputs addr0..3.
REQ-033 The sequencer, counters and output register SHALL live in ntt_addr_seq.

Verification
REQ-034 LOG_N=9, dir=0, out_ready=1 SHALL produce the following.
- 640 quads.
- First quad: stage=4, addresses 0,128,256,384.
- Second quad: addresses 1,129,257,385.
- First quad of stage 3: addresses 0,64,128,192.
- Final quad: stage=0, addresses 508,509,510,511.
- done pulses exactly one cycle after the final handshake.
REQ-035 LOG_N=9, dir=1: stage 0 SHALL come first with first quad 0,1,2,3 and second quad 4,5,6,7; stage 4 SHALL come last; across the whole pass, all 512 addresses SHALL each appear exactly once per stage.
REQ-036 LOG_N=8: there SHALL be 4 stages with no radix-2 stage, 256 quads, and stage_last high on every 64th quad.
REQ-037 Random out_ready at 30% low: outputs SHALL hold stable while stalled, and the quad sequence SHALL be identical to the REQ-034 stream.
REQ-038 rst_n pulsed low at quad 200: out_valid and busy SHALL drop immediately and no done SHALL be emitted; a new start SHALL restart at 0,128,256,384.
REQ-039 start pulsed during RUN and during FIN SHALL have no effect: quad count stays 640 and there is a single done pulse.
